// File: rtl/calc_dispatch2.sv
// calc_dispatch2: dispatches stream jobs to two calc units and retires results in arrival order.
// Optional statistics counters are enabled with `define CALC_DISPATCH2_STATS_EN.
module calc_dispatch2 #(
    parameter int M         = 32,
    parameter bit UNIT_PREF = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [M-1:0] in_data,
    output logic         in_ready,
    output logic         u0_start,
    output logic         u1_start,
    output logic [M-1:0] u_data,
    input  logic         u0_done,
    input  logic         u1_done,
    output logic         u0_ack,
    output logic         u1_ack,
    input  logic         out_ready,
    output logic         mux_sel,
    output logic         out_valid,
`ifdef CALC_DISPATCH2_STATS_EN
    output logic [31:0]  jobs0_cnt,
    output logic [31:0]  jobs1_cnt,
    output logic [31:0]  stall_cnt,
`endif
    output logic [1:0]   pending
);
    logic         busy0_q, busy0_d, busy1_q, busy1_d;
    logic         q0_q, q0_d, q1_q, q1_d;
    logic [1:0]   cnt_q, cnt_d, cnt_s;
    logic         rr_q, rr_d;
    logic [M-1:0] u_data_q, u_data_d;
    logic         u0_start_q, u0_start_d, u1_start_q, u1_start_d;
    logic         u0_ack_q, u0_ack_d, u1_ack_q, u1_ack_d;
    logic         out_valid_q, out_valid_d;
    logic         acc, tgt, head_done, pop, q0_s;

    assign in_ready  = !busy0_q || !busy1_q;
    assign acc       = in_valid && in_ready;
    assign tgt       = (rr_q ? !busy1_q : !busy0_q) ? rr_q : !rr_q;
    assign head_done = q0_q ? u1_done : u0_done;
    assign pop       = (cnt_q != 2'd0) && head_done && out_ready;
    assign mux_sel   = (cnt_q != 2'd0) && q0_q;
    assign pending   = cnt_q;
    assign u0_start  = u0_start_q;
    assign u1_start  = u1_start_q;
    assign u_data    = u_data_q;
    assign u0_ack    = u0_ack_q;
    assign u1_ack    = u1_ack_q;
    assign out_valid = out_valid_q;

    // Next state: the pop shifts the order queue first, then an accept appends at the freed tail.
    always_comb begin
        cnt_s       = cnt_q - {1'b0, pop};
        q0_s        = pop ? q1_q : q0_q;
        cnt_d       = cnt_s + {1'b0, acc};
        q0_d        = (acc && cnt_s == 2'd0) ? tgt : q0_s;
        q1_d        = (acc && cnt_s == 2'd1) ? tgt : (pop ? 1'b0 : q1_q);
        busy0_d     = (busy0_q && !(pop && !q0_q)) || (acc && !tgt);
        busy1_d     = (busy1_q && !(pop && q0_q)) || (acc && tgt);
        rr_d        = acc ? !tgt : rr_q;
        u_data_d    = acc ? in_data : u_data_q;
        u0_start_d  = acc && !tgt;
        u1_start_d  = acc && tgt;
        u0_ack_d    = pop && !q0_q;
        u1_ack_d    = pop && q0_q;
        out_valid_d = pop;
    end

    // State registers with synchronous active-low reset; in-flight jobs are dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy0_q     <= 1'b0;
            busy1_q     <= 1'b0;
            q0_q        <= 1'b0;
            q1_q        <= 1'b0;
            cnt_q       <= 2'd0;
            rr_q        <= UNIT_PREF;
            u_data_q    <= '0;
            u0_start_q  <= 1'b0;
            u1_start_q  <= 1'b0;
            u0_ack_q    <= 1'b0;
            u1_ack_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            busy0_q     <= busy0_d;
            busy1_q     <= busy1_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            u_data_q    <= u_data_d;
            u0_start_q  <= u0_start_d;
            u1_start_q  <= u1_start_d;
            u0_ack_q    <= u0_ack_d;
            u1_ack_q    <= u1_ack_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef CALC_DISPATCH2_STATS_EN
    logic [31:0] jobs0_q, jobs1_q, stall_q;
    assign jobs0_cnt = jobs0_q;
    assign jobs1_cnt = jobs1_q;
    assign stall_cnt = stall_q;

    // Per-unit start counts and head-ready-but-blocked cycles, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            jobs0_q <= '0;
            jobs1_q <= '0;
            stall_q <= '0;
        end else begin
            if (u0_start_d) jobs0_q <= jobs0_q + 32'd1;
            if (u1_start_d) jobs1_q <= jobs1_q + 32'd1;
            if (cnt_q != 2'd0 && head_done && !out_ready) stall_q <= stall_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_calc_dispatch2.sv
// tb_calc_dispatch2: directed checks of dispatch, in-order retire, backpressure and reset.
module tb_calc_dispatch2;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        u0_start, u1_start;
    logic [31:0] u_data;
    logic        u0_done = 1'b0, u1_done = 1'b0;
    logic        u0_ack, u1_ack;
    logic        out_ready = 1'b1;
    logic        mux_sel, out_valid;
    logic [1:0]  pending;
    int          checks = 0;
    int          errors = 0;

    calc_dispatch2 dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .u0_start(u0_start), .u1_start(u1_start), .u_data(u_data),
        .u0_done(u0_done), .u1_done(u1_done), .u0_ack(u0_ack), .u1_ack(u1_ack),
        .out_ready(out_ready), .mux_sel(mux_sel), .out_valid(out_valid), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        u0_done  = 1'b0;
        u1_done  = 1'b0;
        out_ready = 1'b1;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_pending", 32'(pending), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_mux_sel", 32'(mux_sel), 0);
        chk("rst_u_data", u_data, 0);
        chk("rst_starts", {30'd0, u1_start, u0_start}, 0);
        chk("rst_acks", {30'd0, u1_ack, u0_ack}, 0);

        in_valid = 1'b1; in_data = 32'h0000_00A5;
        tick();
        in_valid = 1'b0;
        chk("j1_u0_start", 32'(u0_start), 1);
        chk("j1_u1_start", 32'(u1_start), 0);
        chk("j1_u_data", u_data, 32'hA5);
        chk("j1_pending", 32'(pending), 1);
        tick();
        chk("j1_start_pulse", 32'(u0_start), 0);
        tick();
        tick();
        u0_done = 1'b1;
        chk("j1_mux_sel", 32'(mux_sel), 0);
        chk("j1_no_valid_yet", 32'(out_valid), 0);
        tick();
        chk("j1_u0_ack", 32'(u0_ack), 1);
        chk("j1_out_valid", 32'(out_valid), 1);
        chk("j1_pending0", 32'(pending), 0);
        u0_done = 1'b0;
        tick();
        chk("j1_ack_pulse", 32'(u0_ack), 0);
        chk("j1_valid_pulse", 32'(out_valid), 0);

        do_reset();
        in_valid = 1'b1; in_data = 32'h11;
        tick();
        chk("b2b_u0_start", 32'(u0_start), 1);
        chk("b2b_u_data0", u_data, 32'h11);
        chk("b2b_ready1", 32'(in_ready), 1);
        in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        chk("b2b_u1_start", 32'(u1_start), 1);
        chk("b2b_u0_off", 32'(u0_start), 0);
        chk("b2b_u_data1", u_data, 32'h22);
        chk("b2b_pending2", 32'(pending), 2);
        chk("b2b_ready0", 32'(in_ready), 0);

        u1_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ooo_no_u1_ack", 32'(u1_ack), 0);
            chk("ooo_no_valid", 32'(out_valid), 0);
            chk("ooo_pending", 32'(pending), 2);
            chk("ooo_mux_sel0", 32'(mux_sel), 0);
            tick();
        end
        u0_done = 1'b1;
        chk("ooo_head_sel", 32'(mux_sel), 0);
        tick();
        chk("ooo_u0_ack", 32'(u0_ack), 1);
        chk("ooo_u1_ack_held", 32'(u1_ack), 0);
        chk("ooo_valid0", 32'(out_valid), 1);
        chk("ooo_pending1", 32'(pending), 1);
        chk("ooo_mux_sel1", 32'(mux_sel), 1);
        u0_done = 1'b0;
        tick();
        chk("ooo_u1_ack", 32'(u1_ack), 1);
        chk("ooo_u0_ack_off", 32'(u0_ack), 0);
        chk("ooo_valid1", 32'(out_valid), 1);
        chk("ooo_pending0", 32'(pending), 0);
        u1_done = 1'b0;
        tick();
        chk("ooo_valid_off", 32'(out_valid), 0);
        chk("ooo_empty_sel", 32'(mux_sel), 0);

        do_reset();
        in_valid = 1'b1; in_data = 32'h44;
        tick();
        in_valid = 1'b0;
        tick();
        u0_done = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_no_ack", 32'(u0_ack), 0);
            chk("bp_no_valid", 32'(out_valid), 0);
            chk("bp_pending", 32'(pending), 1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_ack", 32'(u0_ack), 1);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_pending0", 32'(pending), 0);
        u0_done = 1'b0;
        tick();

        do_reset();
        in_valid = 1'b1; in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        tick();
        u0_done = 1'b1; in_valid = 1'b1; in_data = 32'h33;
        chk("sim_ready", 32'(in_ready), 1);
        chk("sim_sel", 32'(mux_sel), 0);
        tick();
        in_valid = 1'b0; u0_done = 1'b0;
        chk("sim_u0_ack", 32'(u0_ack), 1);
        chk("sim_u1_start", 32'(u1_start), 1);
        chk("sim_u0_start", 32'(u0_start), 0);
        chk("sim_u_data", u_data, 32'h33);
        chk("sim_pending", 32'(pending), 1);
        chk("sim_valid", 32'(out_valid), 1);
        chk("sim_head1", 32'(mux_sel), 1);
        u1_done = 1'b1;
        tick();
        chk("sim_u1_ack", 32'(u1_ack), 1);
        chk("sim_pending0", 32'(pending), 0);
        u1_done = 1'b0;
        tick();

        do_reset();
        in_valid = 1'b1; in_data = 32'h66;
        tick();
        in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        chk("rr_pending2", 32'(pending), 2);
        reset_n = 1'b0; u0_done = 1'b1; out_ready = 1'b1;
        tick();
        chk("mr_pending", 32'(pending), 0);
        chk("mr_in_ready", 32'(in_ready), 1);
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_acks", {30'd0, u1_ack, u0_ack}, 0);
        reset_n = 1'b1; u0_done = 1'b0;
        tick();
        chk("mr_acks_after", {30'd0, u1_ack, u0_ack}, 0);
        chk("mr_valid_after", 32'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
